// File: rtl/seg_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_controller_if
// Description : Interface bundling the value-load handshake and the
//               digit-drive outputs of the seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_controller_if;
    logic        ENABLE;
    logic [15:0] VALUE_IN;
    logic [3:0]  DOT_IN;
    logic        LOAD;
    logic        READY;
    logic [3:0]  BINARY;
    logic [1:0]  SEGMENT;
    logic        DOT;
    logic        BLANK;
    logic        FRAME_DONE;

    // Producer side: offers values and enables the display
    modport master (
        output ENABLE, VALUE_IN, DOT_IN, LOAD,
        input  READY, BINARY, SEGMENT, DOT, BLANK, FRAME_DONE
    );

    // Controller side
    modport slave (
        input  ENABLE, VALUE_IN, DOT_IN, LOAD,
        output READY, BINARY, SEGMENT, DOT, BLANK, FRAME_DONE
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_controller
// Description : Time-multiplexes a 16-bit hex value onto a four-digit
//               seven-segment decoder with per-digit dots, optional
//               leading-zero blanking and frame-aligned (tear-free) updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_controller #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    seg_scan_controller_if.slave  bus
);

    localparam int                c_CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           seg_q, seg_d;
    logic [15:0]          disp_q, disp_d;
    logic [3:0]           disp_dot_q, disp_dot_d;
    logic [15:0]          pend_q, pend_d;
    logic [3:0]           pend_dot_q, pend_dot_d;
    logic                 pend_valid_q, pend_valid_d;

    logic [3:0]           binary_q, binary_d;
    logic [1:0]           segment_q, segment_d;
    logic                 dot_q, dot_d;
    logic                 blank_q, blank_d;
    logic                 frame_done_q, frame_done_d;

    logic                 w_ready;
    logic                 w_xfer;

    assign w_ready = !pend_valid_q;

    // True when digit s is a leading zero: s is not the units digit and
    // every digit from s upward is zero.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] s);
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((j >= int'(s)) && (v[4*j +: 4] != 4'h0)) begin
                nz = 1'b1;
            end
        end
        return (s != 2'd0) && !nz;
    endfunction

    // Scan sequencing, frame-boundary transfer and load capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seg_d        = seg_q;
        disp_d       = disp_q;
        disp_dot_d   = disp_dot_q;
        pend_d       = pend_q;
        pend_dot_d   = pend_dot_q;
        pend_valid_d = pend_valid_q;
        frame_done_d = 1'b0;
        w_xfer       = 1'b0;

        case (state_q)
            ST_OFF: begin
                cnt_d  = '0;
                seg_d  = 2'd0;
                // Display is dark, so a pending value can be applied at once
                w_xfer = pend_valid_q;
                if (bus.ENABLE) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!bus.ENABLE) begin
                    // Abandon the frame: no FRAME_DONE, no transfer
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    seg_d   = 2'd0;
                end else if (cnt_q == c_CNT_LAST) begin
                    cnt_d = '0;
                    seg_d = seg_q + 2'd1;
                    if (seg_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        w_xfer       = pend_valid_q;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
                seg_d   = 2'd0;
            end
        endcase

        if (w_xfer) begin
            disp_d       = pend_q;
            disp_dot_d   = pend_dot_q;
            pend_valid_d = 1'b0;
        end

        // Transfer needs pend_valid set and capture needs it clear, so the
        // two never coincide on one edge.
        if (bus.LOAD && w_ready) begin
            pend_d       = bus.VALUE_IN;
            pend_dot_d   = bus.DOT_IN;
            pend_valid_d = 1'b1;
        end
    end

    // Decoder drive computed from post-edge state so outputs can be registered
    always_comb begin
        segment_d = 2'd0;
        binary_d  = 4'h0;
        dot_d     = 1'b1;
        blank_d   = 1'b1;
        if (state_d == ST_SCAN) begin
            segment_d = seg_d;
            binary_d  = disp_d[{seg_d, 2'b00} +: 4];
            dot_d     = !disp_dot_d[seg_d];
            blank_d   = BLANK_LEADING ? leading_zero(disp_d, seg_d) : 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            seg_q        <= 2'd0;
            disp_q       <= 16'h0000;
            disp_dot_q   <= 4'h0;
            pend_q       <= 16'h0000;
            pend_dot_q   <= 4'h0;
            pend_valid_q <= 1'b0;
            binary_q     <= 4'h0;
            segment_q    <= 2'd0;
            dot_q        <= 1'b1;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_d;
            disp_q       <= disp_d;
            disp_dot_q   <= disp_dot_d;
            pend_q       <= pend_d;
            pend_dot_q   <= pend_dot_d;
            pend_valid_q <= pend_valid_d;
            binary_q     <= binary_d;
            segment_q    <= segment_d;
            dot_q        <= dot_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.READY      = w_ready;
    assign bus.BINARY     = binary_q;
    assign bus.SEGMENT    = segment_q;
    assign bus.DOT        = dot_q;
    assign bus.BLANK      = blank_q;
    assign bus.FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire
